// File: rtl/audio_pkg.sv
// Shared definitions for the PWM audio capture path: default sample width,
// frame length and the capture FSM state encoding.
package audio_pkg;

  localparam int PWM_BITS_DEF = 8;
  localparam int SAMPLE_W     = PWM_BITS_DEF;
  localparam int FRAME_LEN    = 2 ** PWM_BITS_DEF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    MEASURE = 2'd2
  } cap_state_e;

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through sample buffer with registered push and
// wrap-bit pointers for full/empty detection.
module sample_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             wr_en;
  logic             rd_en;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // A simultaneous pop frees the head slot, so a push into a full buffer still lands.
  assign wr_en    = push && (!full || pop);
  assign rd_en    = pop && !empty;
  assign data_out = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (wr_en) begin
      mem_d[wr_ptr_q[AW-1:0]] = data_in;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/pwm_audio_capture.sv
// Recovers one sample per PWM frame by counting high cycles, aligning to the
// first rising edge and then measuring contiguous frames into a small FIFO.
module pwm_audio_capture
  import audio_pkg::*;
#(
  parameter int PWM_BITS   = PWM_BITS_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                pwm_in,
  output logic [PWM_BITS-1:0] sample_data,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                overflow,
  output logic                locked
);

  localparam logic [PWM_BITS-1:0] FC_LAST = '1;
  localparam logic [PWM_BITS-1:0] FC_ONE  = PWM_BITS'(1);
  localparam logic [PWM_BITS:0]   HC_ONE  = (PWM_BITS+1)'(1);

  cap_state_e            state_q, state_d;
  logic                  sync1_q, pwm_s_q, pwm_prev_q;
  logic [PWM_BITS-1:0]   fc_q, fc_d;
  logic [PWM_BITS:0]     hc_q, hc_d;
  logic [PWM_BITS:0]     hc_inc;
  logic                  overflow_q, overflow_d;
  logic                  rise;
  logic                  frame_last;
  logic                  push;
  logic [PWM_BITS-1:0]   push_data;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;

  // A full-high frame counts 2**PWM_BITS, one past the sample range.
  function automatic logic [PWM_BITS-1:0] sat_count(input logic [PWM_BITS:0] c);
    if (c[PWM_BITS]) begin
      return '1;
    end
    return c[PWM_BITS-1:0];
  endfunction

  assign rise       = pwm_s_q && !pwm_prev_q;
  assign frame_last = (fc_q == FC_LAST);
  assign hc_inc     = hc_q + {{PWM_BITS{1'b0}}, pwm_s_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b0;
      pwm_s_q    <= 1'b0;
      pwm_prev_q <= 1'b0;
      fc_q       <= '0;
      hc_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= pwm_in;
      pwm_s_q    <= sync1_q;
      pwm_prev_q <= pwm_s_q;
      fc_q       <= fc_d;
      hc_q       <= hc_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = SYNC;
        SYNC:    if (rise) state_d = MEASURE;
        MEASURE: state_d = MEASURE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    locked = (state_q == MEASURE);
  end

  // Frame counting; the rise cycle itself is frame cycle 0 of the first frame.
  always_comb begin
    fc_d      = fc_q;
    hc_d      = hc_q;
    push      = 1'b0;
    push_data = '0;
    if (!enable || state_q == IDLE) begin
      fc_d = '0;
      hc_d = '0;
    end else if (state_q == SYNC) begin
      if (rise) begin
        fc_d = FC_ONE;
        hc_d = HC_ONE;
      end else if (frame_last) begin
        push = 1'b1;
        fc_d = '0;
      end else begin
        fc_d = fc_q + FC_ONE;
      end
    end else begin
      if (frame_last) begin
        push      = 1'b1;
        push_data = sat_count(hc_inc);
        fc_d      = '0;
        hc_d      = '0;
      end else begin
        fc_d = fc_q + FC_ONE;
        hc_d = hc_inc;
      end
    end
  end

  assign pop          = sample_valid && sample_ready;
  assign sample_valid = !fifo_empty;
  assign overflow     = overflow_q;

  always_comb begin
    overflow_d = overflow_q | (push && fifo_full && !pop);
  end

  sample_fifo #(
    .WIDTH (PWM_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .data_in  (push_data),
    .full     (fifo_full),
    .pop      (pop),
    .data_out (sample_data),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_pwm_audio_capture.sv
// Self-checking bench for pwm_audio_capture: PWM frames with known high-times
// are driven and the consumed samples are compared with a frame-level model.
module tb_pwm_audio_capture;

  localparam int FL = 256;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic       pwm_in = 1'b0;
  logic       sample_ready = 1'b0;
  logic [7:0] sample_data;
  logic       sample_valid;
  logic       overflow;
  logic       locked;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int locked_hi_cnt = 0;

  logic [7:0] got_q[$];
  int         got_t[$];
  int         hs_q[$];
  int         exp_q[$];
  bit         exp_ovf;

  pwm_audio_capture #(.PWM_BITS(8), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .pwm_in       (pwm_in),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overflow     (overflow),
    .locked       (locked)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer-side monitor, sampled mid low phase after inputs have settled.
  always @(negedge clk) begin
    #2;
    if (rst_n && sample_valid && sample_ready) begin
      got_q.push_back(sample_data);
      got_t.push_back(cyc);
    end
    if (locked) locked_hi_cnt++;
  end

  function automatic int recovered(input int h);
    return (h > FL - 1) ? FL - 1 : h;
  endfunction

  // Frame-level model: each frame yields its saturated high-time, kept only if the buffer has room.
  function automatic void build_expect(input int cap);
    exp_q.delete();
    exp_ovf = 1'b0;
    foreach (hs_q[i]) begin
      if (exp_q.size() < cap) exp_q.push_back(recovered(hs_q[i]));
      else exp_ovf = 1'b1;
    end
  endfunction

  task automatic clear_mon();
    got_q.delete();
    got_t.delete();
    locked_hi_cnt = 0;
  endtask

  task automatic drive_frame(input int h);
    for (int i = 0; i < FL; i++) begin
      @(negedge clk);
      pwm_in = (i < h);
    end
  endtask

  task automatic run_stream(output int m0);
    @(negedge clk);
    enable = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    m0 = cyc + 1;
    foreach (hs_q[k]) drive_frame(hs_q[k]);
    repeat (8) @(negedge clk);
    @(negedge clk);
    enable = 1'b0;
    pwm_in = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    sample_ready = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({sample_valid, overflow, locked} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_flags: valid/ovf/locked=%b required 000", {sample_valid, overflow, locked});
    end
    tests_run++;
    if (sample_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_data: got %h required 00", sample_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (sample_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle_valid: got %b required 0", sample_valid);
    end
  endtask

  task automatic test_silence();
    int m;
    sample_ready = 1'b1;
    pwm_in = 1'b0;
    clear_mon();
    @(negedge clk);
    enable = 1'b1;
    m = cyc;
    repeat (800) @(negedge clk);
    enable = 1'b0;
    repeat (4) @(negedge clk);
    tests_run++;
    if (got_q.size() != 3) begin
      tests_failed++;
      $display("FAIL silence_count: got %0d samples required 3", got_q.size());
    end else begin
      // Enable is taken at edge m+1 (SYNC entry); 256 SYNC cycles later the push becomes visible.
      tests_run++;
      if (got_t[0] != m + 257) begin
        tests_failed++;
        $display("FAIL silence_first_time: cycle %0d required %0d", got_t[0], m + 257);
      end
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (got_q[i] !== 8'h00) begin
          tests_failed++;
          $display("FAIL silence_value[%0d]: got %h required 00", i, got_q[i]);
        end
        if (i > 0) begin
          tests_run++;
          if (got_t[i] - got_t[i-1] != FL) begin
            tests_failed++;
            $display("FAIL silence_spacing[%0d]: got %0d required %0d", i, got_t[i] - got_t[i-1], FL);
          end
        end
      end
    end
    tests_run++;
    if (locked_hi_cnt != 0) begin
      tests_failed++;
      $display("FAIL silence_locked: locked high %0d cycles required 0", locked_hi_cnt);
    end
  endtask

  task automatic test_half_duty();
    int m0;
    sample_ready = 1'b1;
    clear_mon();
    hs_q.delete();
    repeat (4) hs_q.push_back(128);
    build_expect(1000);
    run_stream(m0);
    tests_run++;
    if (got_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL half_count: got %0d required %0d", got_q.size(), exp_q.size());
    end else begin
      tests_run++;
      if (got_t[0] != m0 + 258) begin
        tests_failed++;
        $display("FAIL half_first_time: cycle %0d required %0d", got_t[0], m0 + 258);
      end
      foreach (exp_q[i]) begin
        tests_run++;
        if (got_q[i] !== 8'(exp_q[i])) begin
          tests_failed++;
          $display("FAIL half_value[%0d]: got %h required %h", i, got_q[i], 8'(exp_q[i]));
        end
        if (i > 0) begin
          tests_run++;
          if (got_t[i] - got_t[i-1] != FL) begin
            tests_failed++;
            $display("FAIL half_spacing[%0d]: got %0d required %0d", i, got_t[i] - got_t[i-1], FL);
          end
        end
      end
    end
    // Locked from two cycles after the first rise reaches the input until disable takes effect.
    tests_run++;
    if (locked_hi_cnt != hs_q.size() * FL + 6) begin
      tests_failed++;
      $display("FAIL half_locked_cycles: got %0d required %0d", locked_hi_cnt, hs_q.size() * FL + 6);
    end
  endtask

  task automatic test_hold_high();
    int m0;
    sample_ready = 1'b1;
    clear_mon();
    hs_q.delete();
    repeat (3) hs_q.push_back(FL);
    build_expect(1000);
    run_stream(m0);
    tests_run++;
    if (got_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL high_count: got %0d required %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        tests_run++;
        if (got_q[i] !== 8'(exp_q[i])) begin
          tests_failed++;
          $display("FAIL high_value[%0d]: got %h required %h", i, got_q[i], 8'(exp_q[i]));
        end
      end
    end
    tests_run++;
    if (overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL high_overflow: got %b required 0", overflow);
    end
  endtask

  task automatic test_random();
    int m0;
    sample_ready = 1'b1;
    clear_mon();
    hs_q.delete();
    hs_q.push_back(int'($urandom_range(FL, 1)));
    repeat (7) hs_q.push_back(int'($urandom_range(FL, 0)));
    build_expect(1000);
    run_stream(m0);
    tests_run++;
    if (got_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL random_count: got %0d required %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        tests_run++;
        if (got_q[i] !== 8'(exp_q[i])) begin
          tests_failed++;
          $display("FAIL random_value[%0d] (h=%0d): got %h required %h", i, hs_q[i], got_q[i], 8'(exp_q[i]));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int m0;
    sample_ready = 1'b0;
    clear_mon();
    hs_q.delete();
    repeat (5) hs_q.push_back(int'($urandom_range(FL - 1, 1)));
    build_expect(1000);
    @(negedge clk);
    enable = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    m0 = cyc + 1;
    fork
      begin
        foreach (hs_q[k]) drive_frame(hs_q[k]);
      end
      begin
        // Pop lands on the same edge that pushes the fifth frame into the full buffer.
        repeat (4 * FL + 258) @(negedge clk);
        sample_ready = 1'b1;
        @(negedge clk);
        sample_ready = 1'b0;
      end
    join
    tests_run++;
    if ({sample_valid, overflow} !== 2'b10) begin
      tests_failed++;
      $display("FAIL b2b_state: valid/ovf=%b required 10", {sample_valid, overflow});
    end
    repeat (8) @(negedge clk);
    enable = 1'b0;
    pwm_in = 1'b0;
    sample_ready = 1'b1;
    repeat (10) @(negedge clk);
    tests_run++;
    if (got_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d required %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        tests_run++;
        if (got_q[i] !== 8'(exp_q[i])) begin
          tests_failed++;
          $display("FAIL b2b_value[%0d]: got %h required %h", i, got_q[i], 8'(exp_q[i]));
        end
      end
    end
    tests_run++;
    if (overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_overflow: got %b required 0", overflow);
    end
  endtask

  task automatic test_overflow();
    int m0;
    sample_ready = 1'b0;
    clear_mon();
    hs_q.delete();
    for (int i = 1; i <= 6; i++) hs_q.push_back(16 * i);
    build_expect(4);
    run_stream(m0);
    tests_run++;
    if ({sample_valid, overflow} !== {1'b1, exp_ovf}) begin
      tests_failed++;
      $display("FAIL ovf_state: valid/ovf=%b required 1%b", {sample_valid, overflow}, exp_ovf);
    end
    sample_ready = 1'b1;
    repeat (10) @(negedge clk);
    tests_run++;
    if (got_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL ovf_count: got %0d required %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        tests_run++;
        if (got_q[i] !== 8'(exp_q[i])) begin
          tests_failed++;
          $display("FAIL ovf_value[%0d]: got %h required %h", i, got_q[i], 8'(exp_q[i]));
        end
      end
    end
    tests_run++;
    if ({sample_valid, overflow} !== 2'b01) begin
      tests_failed++;
      $display("FAIL ovf_drained: valid/ovf=%b required 01", {sample_valid, overflow});
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tests_run++;
    if (overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_reset_clear: got %b required 0", overflow);
    end
  endtask

  task automatic test_enable_drop();
    int m0;
    sample_ready = 1'b1;
    clear_mon();
    @(negedge clk);
    enable = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      pwm_in = (i < 128);
    end
    @(negedge clk);
    enable = 1'b0;
    pwm_in = 1'b0;
    @(negedge clk);
    tests_run++;
    if (locked !== 1'b0) begin
      tests_failed++;
      $display("FAIL drop_locked: got %b required 0", locked);
    end
    repeat (300) @(negedge clk);
    tests_run++;
    if (got_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drop_no_push: got %0d samples required 0", got_q.size());
    end
    hs_q.delete();
    repeat (2) hs_q.push_back(128);
    build_expect(1000);
    run_stream(m0);
    tests_run++;
    if (got_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL relock_count: got %0d required %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        tests_run++;
        if (got_q[i] !== 8'(exp_q[i])) begin
          tests_failed++;
          $display("FAIL relock_value[%0d]: got %h required %h", i, got_q[i], 8'(exp_q[i]));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    sample_ready = 1'b0;
    clear_mon();
    @(negedge clk);
    enable = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    drive_frame(128);
    drive_frame(128);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      pwm_in = (i < 128);
    end
    tests_run++;
    if ({sample_valid, locked} !== 2'b11) begin
      tests_failed++;
      $display("FAIL midrst_before: valid/locked=%b required 11", {sample_valid, locked});
    end
    #3 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({sample_valid, overflow, locked, sample_data} !== 11'b0) begin
      tests_failed++;
      $display("FAIL midrst_outputs: valid/ovf/locked/data=%b required all 0",
               {sample_valid, overflow, locked, sample_data});
    end
    @(negedge clk);
    enable = 1'b0;
    pwm_in = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_silence();
    test_half_duty();
    test_hold_high();
    test_random();
    test_back_to_back();
    test_overflow();
    test_enable_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
